// File: rtl/data_window_fmt.sv
// data_window_fmt: drains SDRAM lines from the pre FIFO and forwards a per-line word window
// to the post FIFO. Define FMT_STATS_EN to add the fwd_total/drop_total run counters.
module data_window_fmt #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned LVL_W      = 15,
    parameter int unsigned LINE_W     = 16,
    parameter int unsigned PRE_THRESH = 10,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [CNT_W-1:0]  skip_length,
    input  logic [CNT_W-1:0]  frame_length,
    input  logic [CNT_W-1:0]  sdram_length,
    input  logic [LINE_W-1:0] line_count,
    input  logic [LVL_W-1:0]  fifo_num_pre,
    input  logic              fifo_post_ready,
    output logic              fifo_rden,
    output logic              fifo_wren,
    output logic              busy,
    output logic              done,
    output logic              err_cfg
`ifdef FMT_STATS_EN
    ,
    output logic [CNT_W-1:0]  fwd_total,
    output logic [CNT_W-1:0]  drop_total
`endif
);

    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, SKIP, FWD, DRAIN, GAP, EOL, DONE} state_t;

    state_t              state_q, state_d, ret_q, ret_d, nxt;
    logic [2:0]          sync_q, sync_d;
    logic                pre_ok_q, pre_ok_d, fwd_ok_q, fwd_ok_d;
    logic                gap_q, gap_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [CNT_W-1:0]    word_q, word_d, word_inc;
    logic [LINE_W-1:0]   line_q, line_d, line_inc;
    logic [CNT_W-1:0]    skip_end_q, skip_end_d, fwd_end_q, fwd_end_d, sdram_q, sdram_d;
    logic [LINE_W-1:0]   lines_q, lines_d;
    logic                err_q, err_d;
    logic                rden_q, rden_d, wren_q, wren_d, busy_q, busy_d, done_q, done_d;
    logic [CNT_W:0]      cfg_sum;
    logic                cfg_bad, trig;
    logic [CNT_W-1:0]    lim;
    logic                ok, rd_state, lim_met, rd_cycle;
`ifdef FMT_STATS_EN
    logic [CNT_W-1:0]    fwd_total_q, fwd_total_d, drop_total_q, drop_total_d;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            sync_q     <= '0;
            pre_ok_q   <= 1'b0;
            fwd_ok_q   <= 1'b0;
            gap_q      <= 1'b0;
            burst_q    <= '0;
            word_q     <= '0;
            line_q     <= '0;
            skip_end_q <= '0;
            fwd_end_q  <= '0;
            sdram_q    <= '0;
            lines_q    <= '0;
            err_q      <= 1'b0;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef FMT_STATS_EN
            fwd_total_q  <= '0;
            drop_total_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            sync_q     <= sync_d;
            pre_ok_q   <= pre_ok_d;
            fwd_ok_q   <= fwd_ok_d;
            gap_q      <= gap_d;
            burst_q    <= burst_d;
            word_q     <= word_d;
            line_q     <= line_d;
            skip_end_q <= skip_end_d;
            fwd_end_q  <= fwd_end_d;
            sdram_q    <= sdram_d;
            lines_q    <= lines_d;
            err_q      <= err_d;
            rden_q     <= rden_d;
            wren_q     <= wren_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef FMT_STATS_EN
            fwd_total_q  <= fwd_total_d;
            drop_total_q <= drop_total_d;
`endif
        end
    end

    // Synchroniser, registered FIFO qualification and per-phase read decision.
    always_comb begin
        sync_d   = {sync_q[1:0], start};
        trig     = sync_q[1] & ~sync_q[2];
        pre_ok_d = (fifo_num_pre > LVL_W'(PRE_THRESH));
        fwd_ok_d = pre_ok_q & fifo_post_ready;
        cfg_sum  = {1'b0, skip_length} + {1'b0, frame_length};
        cfg_bad  = (cfg_sum > {1'b0, sdram_length});
        lim      = sdram_q;
        ok       = pre_ok_q;
        nxt      = EOL;
        rd_state = 1'b0;
        case (state_q)
            SKIP: begin
                lim      = skip_end_q;
                nxt      = FWD;
                rd_state = 1'b1;
            end
            FWD: begin
                lim      = fwd_end_q;
                ok       = fwd_ok_q;
                nxt      = DRAIN;
                rd_state = 1'b1;
            end
            DRAIN: rd_state = 1'b1;
            default: ;
        endcase
        lim_met  = (word_q >= lim);
        rd_cycle = rd_state & ~lim_met & ok & (burst_q < BURST_MAX);
        word_inc = word_q + CNT_W'(1);
        line_inc = line_q + LINE_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        gap_d      = gap_q;
        burst_d    = burst_q;
        word_d     = word_q;
        line_d     = line_q;
        skip_end_d = skip_end_q;
        fwd_end_d  = fwd_end_q;
        sdram_d    = sdram_q;
        lines_d    = lines_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    sdram_d = sdram_length;
                    lines_d = (line_count == '0) ? LINE_W'(1) : line_count;
                    err_d   = cfg_bad;
                    // A clipped window always ends exactly at the line length.
                    if (cfg_bad) begin
                        skip_end_d = (skip_length >= sdram_length) ? sdram_length : skip_length;
                        fwd_end_d  = sdram_length;
                    end else begin
                        skip_end_d = skip_length;
                        fwd_end_d  = cfg_sum[CNT_W-1:0];
                    end
                    word_d  = '0;
                    line_d  = '0;
                    state_d = SKIP;
                end
            end
            SKIP, FWD, DRAIN: begin
                if (lim_met) begin
                    state_d = nxt;
                end else if (rd_cycle) begin
                    word_d = word_inc;
                    ret_d  = (word_inc >= lim) ? nxt : state_q;
                    if (burst_q + BW'(1) == BURST_MAX) begin
                        state_d = GAP;
                        gap_d   = 1'b0;
                    end else begin
                        state_d = ret_d;
                    end
                end
            end
            GAP: begin
                gap_d = 1'b1;
                if (gap_q) state_d = ret_q;
            end
            EOL: begin
                line_d  = line_inc;
                word_d  = '0;
                state_d = (line_inc < lines_q) ? SKIP : DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        burst_d = rd_cycle ? burst_q + BW'(1) : '0;
    end

    always_comb begin
        rden_d = rd_cycle;
        wren_d = rd_cycle & (state_q == FWD);
        done_d = (state_q == DONE);
        busy_d = busy_q;
        if (state_q == IDLE && trig) busy_d = 1'b1;
        if (state_q == DONE) busy_d = 1'b0;
`ifdef FMT_STATS_EN
        if (state_q == IDLE && trig) begin
            fwd_total_d  = '0;
            drop_total_d = '0;
        end else begin
            fwd_total_d  = fwd_total_q + (wren_q ? CNT_W'(1) : '0);
            drop_total_d = drop_total_q + ((rden_q & ~wren_q) ? CNT_W'(1) : '0);
        end
`endif
    end

    assign fifo_rden = rden_q;
    assign fifo_wren = wren_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cfg   = err_q;
`ifdef FMT_STATS_EN
    assign fwd_total  = fwd_total_q;
    assign drop_total = drop_total_q;
`endif

endmodule

// File: tb/tb_data_window_fmt.sv
// Self-checking bench for data_window_fmt: per-word forward/discard scoreboard plus
// strobe pacing, readiness and reset scenarios.
module tb_data_window_fmt;

    localparam int BURST = 8;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] skip_length, frame_length, sdram_length;
    logic [15:0] line_count;
    logic [14:0] fifo_num_pre;
    logic        fifo_post_ready;
    logic        fifo_rden, fifo_wren, busy, done, err_cfg;
`ifdef FMT_STATS_EN
    logic [31:0] fwd_total, drop_total;
`endif

    data_window_fmt #(
        .CNT_W(32), .LVL_W(15), .LINE_W(16), .PRE_THRESH(10), .BURST_LEN(BURST)
    ) dut (
        .clk(clk), .RST(RST), .start(start),
        .skip_length(skip_length), .frame_length(frame_length),
        .sdram_length(sdram_length), .line_count(line_count),
        .fifo_num_pre(fifo_num_pre), .fifo_post_ready(fifo_post_ready),
        .fifo_rden(fifo_rden), .fifo_wren(fifo_wren),
        .busy(busy), .done(done), .err_cfg(err_cfg)
`ifdef FMT_STATS_EN
        , .fwd_total(fwd_total), .drop_total(drop_total)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    bit obs_q[$];
    int rd_n, wr_n, done_n, orphan_n, viol_n, lowwr_n, gap1_n, first_wr, skip_rd_before;
    bit timed_out, busy_seen;

    // Expected wren flag for every pre-FIFO read of a run.
    task automatic push_run(input int skip, input int frame, input int sdram, input int lines);
        int eff, nl;
        eff = frame;
        if (skip + frame > sdram) eff = (skip >= sdram) ? 0 : sdram - skip;
        nl = (lines == 0) ? 1 : lines;
        for (int l = 0; l < nl; l++)
            for (int w = 0; w < sdram; w++)
                exp_q.push_back(w >= skip && w < skip + eff);
    endtask

    task automatic configure(input int skip, input int frame, input int sdram, input int lines);
        skip_length  = skip;
        frame_length = frame;
        sdram_length = sdram;
        line_count   = lines[15:0];
    endtask

    // Raises start, holds post-ready low for cycles [lo_from, lo_to) and records the strobes.
    task automatic collect(input int budget, input int lo_from, input int lo_to);
        int cyc, post, run, idle, prev_run;
        bit any_rd, seen_done;
        start = 1'b0;
        fifo_post_ready = 1'b1;
        repeat (4) @(negedge clk);
        rd_n = 0; wr_n = 0; done_n = 0; orphan_n = 0; viol_n = 0; lowwr_n = 0;
        gap1_n = 0; first_wr = -1; skip_rd_before = 0; timed_out = 0; busy_seen = 0;
        obs_q.delete();
        cyc = 0; post = 0; run = 0; idle = 0; prev_run = 0; any_rd = 0; seen_done = 0;
        while (post < 6) begin
            @(negedge clk);
            if (fifo_rden) begin
                rd_n++;
                obs_q.push_back(fifo_wren);
                if (!fifo_wren && cyc < lo_to) skip_rd_before++;
                if (any_rd && idle > 0) begin
                    if (prev_run == BURST && idle < 2) viol_n++;
                    if (idle == 1) gap1_n++;
                end
                idle = 0;
                run++;
                if (run > BURST) viol_n++;
                any_rd = 1;
            end else begin
                if (run > 0) prev_run = run;
                run = 0;
                idle++;
            end
            if (fifo_wren && !fifo_rden) orphan_n++;
            if (fifo_wren) begin
                wr_n++;
                if (cyc >= 2 && (cyc - 2) >= lo_from && (cyc - 2) < lo_to) lowwr_n++;
                if (first_wr < 0 && cyc >= lo_to) first_wr = cyc;
            end
            if (busy) busy_seen = 1;
            if (done) begin
                done_n++;
                seen_done = 1;
            end
            start = (cyc < 5);
            fifo_post_ready = !(cyc >= lo_from && cyc < lo_to);
            if (seen_done) post++;
            cyc++;
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
        end
        start = 1'b0;
        fifo_post_ready = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        #1;
        checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", fifo_rden); end
        checks++; if (fifo_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", fifo_wren); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err_cfg !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_cfg); end
        repeat (3) @(negedge clk);
        RST = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || fifo_rden !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy %b rden %b want 0 0", busy, fifo_rden);
        end
    endtask

    task automatic test_single_line;
        bit e, o;
        configure(2, 4, 10, 1);
        push_run(2, 4, 10, 1);
        collect(200, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL single_timeout done not seen"); end
        checks++; if (rd_n != 10) begin errors++; $display("FAIL single_rden got %0d want 10", rd_n); end
        checks++; if (wr_n != 4) begin errors++; $display("FAIL single_wren got %0d want 4", wr_n); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_n); end
        checks++; if (err_cfg !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err_cfg); end
        checks++; if (orphan_n != 0) begin errors++; $display("FAIL single_orphan got %0d want 0", orphan_n); end
        checks++; if (!busy_seen || busy !== 1'b0) begin
            errors++; $display("FAIL single_busy seen %b final %b want 1 0", busy_seen, busy);
        end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL single_len got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL single_word%0d wren got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
`ifdef FMT_STATS_EN
        checks++; if (fwd_total !== 32'd4 || drop_total !== 32'd6) begin
            errors++; $display("FAIL single_stats fwd %0d drop %0d want 4 6", fwd_total, drop_total);
        end
`endif
    endtask

    task automatic test_multi_line;
        bit e, o;
        configure(2, 4, 10, 3);
        push_run(2, 4, 10, 3);
        collect(300, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL multi_timeout done not seen"); end
        checks++; if (rd_n != 30) begin errors++; $display("FAIL multi_rden got %0d want 30", rd_n); end
        checks++; if (wr_n != 12) begin errors++; $display("FAIL multi_wren got %0d want 12", wr_n); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL multi_done got %0d want 1", done_n); end
        checks++; if (gap1_n != 2) begin errors++; $display("FAIL multi_eol_gaps got %0d want 2", gap1_n); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL multi_len got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL multi_word%0d wren got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_burst;
        bit e, o;
        configure(0, 20, 20, 1);
        push_run(0, 20, 20, 1);
        collect(300, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL burst_timeout done not seen"); end
        checks++; if (rd_n != 20) begin errors++; $display("FAIL burst_rden got %0d want 20", rd_n); end
        checks++; if (wr_n != 20) begin errors++; $display("FAIL burst_wren got %0d want 20", wr_n); end
        checks++; if (viol_n != 0) begin errors++; $display("FAIL burst_pacing violations %0d want 0", viol_n); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL burst_len got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL burst_word%0d wren got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_post_ready;
        bit e, o;
        configure(4, 8, 16, 1);
        push_run(4, 8, 16, 1);
        collect(300, 2, 14);
        checks++; if (timed_out) begin errors++; $display("FAIL ready_timeout done not seen"); end
        checks++; if (lowwr_n != 0) begin errors++; $display("FAIL ready_low_wren got %0d want 0", lowwr_n); end
        checks++; if (skip_rd_before != 4) begin
            errors++; $display("FAIL ready_skip_reads got %0d want 4", skip_rd_before);
        end
        checks++; if (first_wr != 16) begin errors++; $display("FAIL ready_resume got cycle %0d want 16", first_wr); end
        checks++; if (rd_n != 16 || wr_n != 8) begin
            errors++; $display("FAIL ready_counts rden %0d wren %0d want 16 8", rd_n, wr_n);
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL ready_word%0d wren got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_err_cfg;
        bit e, o;
        configure(6, 8, 10, 1);
        push_run(6, 8, 10, 1);
        collect(200, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL err_timeout done not seen"); end
        checks++; if (rd_n != 10 || wr_n != 4) begin
            errors++; $display("FAIL err_counts rden %0d wren %0d want 10 4", rd_n, wr_n);
        end
        repeat (5) @(negedge clk);
        checks++; if (err_cfg !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_cfg); end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL err_word%0d wren got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
        // Next valid trigger clears the flag; line_count 0 runs a single line.
        configure(1, 2, 5, 0);
        collect(200, 0, 0);
        checks++; if (err_cfg !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err_cfg); end
        checks++; if (done_n != 1 || rd_n != 5 || wr_n != 2) begin
            errors++; $display("FAIL lines0 done %0d rden %0d wren %0d want 1 5 2", done_n, rd_n, wr_n);
        end
    endtask

    task automatic test_reset_mid_fwd;
        bit e, o, hit;
        configure(2, 20, 30, 1);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            if (fifo_wren) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL midfwd_timeout wren not seen"); end
        repeat (2) @(negedge clk);
        RST = 1'b1;
        start = 1'b0;
        #1;
        checks++; if (fifo_rden !== 1'b0 || fifo_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midfwd_reset rden %b wren %b busy %b done %b want 0000",
                               fifo_rden, fifo_wren, busy, done);
        end
        @(negedge clk);
        RST = 1'b0;
        push_run(2, 20, 30, 1);
        collect(300, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL rerun_timeout done not seen"); end
        checks++; if (rd_n != 30 || wr_n != 20) begin
            errors++; $display("FAIL rerun_counts rden %0d wren %0d want 30 20", rd_n, wr_n);
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL rerun_word%0d wren got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        RST = 1'b1;
        start = 1'b0;
        fifo_num_pre = 15'd20;
        fifo_post_ready = 1'b1;
        configure(0, 0, 0, 1);
        test_reset;
        test_single_line;
        test_multi_line;
        test_burst;
        test_post_ready;
        test_err_cfg;
        test_reset_mid_fwd;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_window_fmt.md
Name: data_window_fmt

Overview:
Parametrised successor to the single-window frame formatter. It drains one or more SDRAM lines from the upstream (pre) FIFO and applies a per-line window to each: leading words are discarded, a middle window goes to the downstream (post) FIFO, and trailing words are discarded. Reads are paced in bounded bursts against the registered FIFO level. It sits between the SDRAM read FIFO and the output FIFO and is control-only: the read and write strobes are cycle-aligned and the data path is external.

Parameters:
CNT_W, 32, width of the length and word counters
LVL_W, 15, width of the pre-FIFO fill level
LINE_W, 16, width of the line count
PRE_THRESH, 10, pre-FIFO level must be strictly greater than this to read
BURST_LEN, 8, maximum consecutive read cycles before a forced gap; must be < PRE_THRESH

Ports:
clk  in  1  system clock
RST  in  1  asynchronous reset, active-high
start  in  1  run request; asynchronous to clk, 2-FF synchronised internally
skip_length  in  CNT_W  words discarded at the start of each line
frame_length  in  CNT_W  words forwarded per line
sdram_length  in  CNT_W  total words per line
line_count  in  LINE_W  lines per run; 0 is treated as 1
fifo_num_pre  in  LVL_W  pre-FIFO fill level
fifo_post_ready  in  1  post FIFO can accept
fifo_rden  out  1  pre-FIFO read enable
fifo_wren  out  1  post-FIFO write enable
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
err_cfg  out  1  sticky flag: skip_length+frame_length > sdram_length on the latched configuration

Behaviour:
- One clock domain; RST asynchronously clears all state. Reset values: fifo_rden=0, fifo_wren=0, busy=0, done=0, err_cfg=0, counters=0, state=IDLE.
- start passes through 2 flops (s1, s2); a run triggers on the rising edge of s2 (s2 & ~s3). Trigger latency is 3 clk from start rising.
- Qualification is registered: pre_ok <= (fifo_num_pre > PRE_THRESH); fwd_ok <= pre_ok & fifo_post_ready.
- Trigger in IDLE:
  - latch all four length inputs;
  - compute the sum skip+frame in CNT_W+1 bits;
  - if the sum > sdram_length, set err_cfg and clip the effective frame to sdram_length − skip (0 if skip ≥ sdram_length);
  - clear word_cnt and line_cnt; set busy; go to SKIP.
- Triggers while busy are ignored.
- SKIP: a read cycle needs pre_ok and burst room. It drives rden=1, wren=0 and increments word_cnt. Exit to FWD when word_cnt reaches skip.
- FWD: a read cycle needs fwd_ok and burst room. It drives rden=1, wren=1 and increments word_cnt. Exit to DRAIN when word_cnt reaches skip+frame.
- DRAIN: same as SKIP, with exit to EOL when word_cnt reaches sdram_length.
- Any state whose limit is already met passes through in one cycle with no strobes, so zero-length phases are legal.
- Burst pacing:
  - burst_cnt counts consecutive read cycles;
  - when it reaches BURST_LEN, 2 idle cycles (GAP) are forced so pre_ok and fwd_ok reflect the reads already issued;
  - burst_cnt resets on any non-read cycle.
- EOL:
  - strobes are 0; line_cnt increments and word_cnt clears;
  - if line_cnt+1 < effective line_count, go to SKIP; otherwise go to DONE.
- DONE: drive done=1 for one cycle, clear busy, return to IDLE. err_cfg is cleared only by RST or by the next trigger with a valid configuration.
- Strobes are registered and deasserted in every non-read cycle.
- Forwarded word count per line equals the effective frame exactly; total pre-FIFO reads per line equal sdram_length.
- Inputs changing mid-run have no effect, because the configuration is latched.

Optional Feature:
FMT_STATS_EN
- Defined:
  - adds outputs fwd_total [CNT_W] and drop_total [CNT_W];
  - both clear on trigger and count wren cycles and (rden & ~wren) cycles over the run;
  - both are held after done and reset to 0 by RST.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- skip=2, frame=4, sdram=10, lines=1, level=20, ready=1 → exactly 10 rden and 4 wren; the wren pulses are on read #3–#6; done pulses once; err_cfg=0.
- Same configuration with lines=3 → 30 rden, 12 wren, a single done, and a 1-cycle strobe-free EOL gap between lines.
- BURST_LEN=8, skip=0, frame=20, sdram=20 → rden runs of at most 8 cycles separated by at least 2 idle cycles; 20 wren total.
- fifo_post_ready=0 during FWD → no strobes while low; resumes 2 cycles after it rises; the skip phase is unaffected by ready.
- skip=6, frame=8, sdram=10 → err_cfg=1, 4 wren, 10 rden.
- RST asserted mid-FWD → all outputs are 0 in the same cycle; a later start rising edge reruns the line from word 0.
